y_buf_reader: RTL and testbench
===============================

# y_buf_reader

Drains the output-activation buffer after a processing pass and presents the results to the host/DMA side as a valid/ready stream. It is the read-side counterpart of the processing unit's write port: it issues `y_buf_en`/`y_buf_addr` reads against the same synchronous single-port buffer, with one-cycle read latency. A 2-entry skid FIFO absorbs downstream backpressure so that no read word is ever dropped.

## Interface
- `OUT_BUF_ADDR_WIDTH`, 32: buffer address width.
- `OUT_BUF_DATA_WIDTH`, 32: buffer word width, equal to the stream width.
- `CNT_WIDTH`, 16: width of the word-count input.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `drain_start`  in  1  one-cycle start pulse; ignored unless IDLE.
- `base_addr`  in  OUT_BUF_ADDR_WIDTH  first word address; sampled on `drain_start`.
- `num_words`  in  CNT_WIDTH  number of words to read; sampled on `drain_start`.
- `drain_busy`  out  1  high from the cycle after an accepted start until the DONE state.
- `drain_done`  out  1  one-cycle pulse at the end of a drain.
- `y_buf_en`  out  1  buffer access enable, one read per cycle.
- `y_buf_wr_en`  out  1  tied 0; this block never writes.
- `y_buf_addr`  out  OUT_BUF_ADDR_WIDTH  read address.
- `y_buf_rdata`  in  OUT_BUF_DATA_WIDTH  read data, valid the cycle after `y_buf_en`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accept.
- `out_data`  out  OUT_BUF_DATA_WIDTH  stream word, taken from the FIFO head.
- `out_last`  out  1  high with the final word of a drain.

## Operation
- FSM states: IDLE, READ, FLUSH, DONE.
  - IDLE → READ on `drain_start` when `num_words` ≠ 0.
  - IDLE → DONE on `drain_start` when `num_words` = 0; no reads are issued.
  - READ → FLUSH in the cycle the last read is issued.
  - FLUSH → DONE when the last word is accepted (`out_valid && out_ready && out_last`).
  - DONE → IDLE unconditionally after one cycle. `drain_done` is high only in DONE.
- Read counter `rd_left`: loaded with `num_words`; decremented on each issued read. Address register: loaded with `base_addr`; incremented by 1 per read. The address wraps modulo 2^OUT_BUF_ADDR_WIDTH with no flag.
- Issue rule, evaluated in READ: `y_buf_en` = 1 iff (fifo_count + inflight − pop) < 2.
  - pop = `out_valid && out_ready` in the same cycle.
  - inflight = 1 if a read was issued in the previous cycle.
  - This rule guarantees the FIFO never overflows.
- Capture: when inflight = 1, `y_buf_rdata` is pushed into the FIFO at the end of that cycle. A simultaneous push and pop is legal; the count is unchanged.
- Accept counter `acc_left` tracks accepted words. `out_last` = `out_valid` && (`acc_left` == 1).
- `out_data` and `out_last` stay stable while `out_valid && !out_ready`. `out_valid` never drops without an accept.
- A `drain_start` arriving outside IDLE has no effect.
- Reset mid-drain: all state clears immediately. Outstanding read data is discarded and the FIFO is emptied.

## Timing
- Reset values: `drain_busy`=0, `drain_done`=0, `y_buf_en`=0, `y_buf_wr_en`=0, `y_buf_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0.
- With `drain_start` at cycle 0:
  - First `y_buf_en` is at cycle 1.
  - Data is captured at the end of cycle 2.
  - First `out_valid` is at cycle 3.
- With `out_ready` held high: one word per cycle; last word at cycle N+2; `drain_done` at cycle N+3.
- With `num_words` = 0: `drain_done` pulses at cycle 1.
- Latency from stall release to resumed reads: 1 cycle.

## Structure
- Shared package (`pu_pkg`):
  - FSM state enum `rd_state_t`.
  - Default width constants, shared with the processing unit.
  - `SKID_DEPTH` = 2.
- One natural sub-module: `skid_fifo2`, a 2-entry register FIFO with push/pop/count/head. The FSM, counters and issue logic live in `y_buf_reader`.

## Test plan
- Basic drain: `base_addr`=0x10, `num_words`=4, buffer[0x10..0x13] = A,B,C,D, `out_ready`=1 → reads at addresses 0x10–0x13 on cycles 1–4; words A,B,C,D on cycles 3–6 with `out_last` on D; `drain_done` at cycle 7.
- Backpressure: N=8, `out_ready` toggling 1,0,0,1,… → all 8 words delivered in order, no duplicates. `y_buf_en` never issues while FIFO+inflight would exceed 2. Data stays stable while stalled.
- Zero length: `num_words`=0 → no `y_buf_en`, no `out_valid`, `drain_done` at cycle 1.
- Address wrap: OUT_BUF_ADDR_WIDTH=4, `base_addr`=0xE, N=4 → addresses E, F, 0, 1.
- Start while busy: second `drain_start` mid-drain with different parameters → ignored; the original drain completes unchanged.
- Reset mid-drain: deassert `rst_n` after 2 words are accepted → all outputs go to reset values. A new drain afterwards (N=3) runs cleanly from its own base.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared definitions for the processing unit and its output-buffer reader.
package pu_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/y_buf_reader_skid_fifo2.sv
// Two-entry register FIFO; the head word is presented combinationally from r_mem0.
module skid_fifo2
    import pu_pkg::*;
#(
    parameter int DW = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_din,
    input  logic          i_pop,
    output logic [1:0]    o_count,
    output logic [DW-1:0] o_head
);

    logic [DW-1:0] r_mem0;
    logic [DW-1:0] r_mem1;
    logic [1:0]    r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem0  <= '0;
            r_mem1  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_mem0 <= i_din;
                    else                 r_mem1 <= i_din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_mem0  <= r_mem1;
                    r_count <= r_count - 2'd1;
                end
                // Simultaneous push/pop keeps the count; the new word lands behind any survivor.
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_din;
                    end else begin
                        r_mem0 <= i_din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem0;

endmodule

// File: rtl/y_buf_reader.sv
// Drains the output-activation buffer into a valid/ready stream, using a
// 2-entry skid FIFO so backpressure never drops a word already read.
module y_buf_reader
    import pu_pkg::*;
#(
    parameter int OUT_BUF_ADDR_WIDTH = DEF_ADDR_W,
    parameter int OUT_BUF_DATA_WIDTH = DEF_DATA_W,
    parameter int CNT_WIDTH          = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          drain_start,
    input  logic [OUT_BUF_ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]          num_words,
    output logic                          drain_busy,
    output logic                          drain_done,
    output logic                          y_buf_en,
    output logic                          y_buf_wr_en,
    output logic [OUT_BUF_ADDR_WIDTH-1:0] y_buf_addr,
    input  logic [OUT_BUF_DATA_WIDTH-1:0] y_buf_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BUF_DATA_WIDTH-1:0] out_data,
    output logic                          out_last
);

    localparam logic [CNT_WIDTH-1:0]          CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [OUT_BUF_ADDR_WIDTH-1:0] ADDR_ONE = {{(OUT_BUF_ADDR_WIDTH-1){1'b0}}, 1'b1};

    rd_state_t                     r_state;
    logic [OUT_BUF_ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]          r_rd_left;
    logic [CNT_WIDTH-1:0]          r_acc_left;
    logic                          r_inflight;
    logic                          r_busy;
    logic                          r_done;

    logic [1:0] w_count;
    logic       w_pop;
    logic       w_last;
    logic       w_en;
    logic [2:0] w_occ;

    assign w_pop  = out_valid && out_ready;
    assign w_last = out_valid && (r_acc_left == CNT_ONE);

    // Words buffered or still on their way, net of the one leaving this cycle.
    assign w_occ = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_en  = (r_state == ST_READ) && (w_occ < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_rd_left  <= '0;
            r_acc_left <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_en;
            r_done     <= 1'b0;
            if (w_en)  r_addr     <= r_addr + ADDR_ONE;
            if (w_pop) r_acc_left <= r_acc_left - CNT_ONE;
            case (r_state)
                ST_IDLE: begin
                    if (drain_start) begin
                        r_addr     <= base_addr;
                        r_rd_left  <= num_words;
                        r_acc_left <= num_words;
                        if (num_words != '0) begin
                            r_state <= ST_READ;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (w_en) begin
                        r_rd_left <= r_rd_left - CNT_ONE;
                        if (r_rd_left == CNT_ONE) r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_pop && w_last) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    skid_fifo2 #(
        .DW(OUT_BUF_DATA_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_inflight),
        .i_din  (y_buf_rdata),
        .i_pop  (w_pop),
        .o_count(w_count),
        .o_head (out_data)
    );

    assign out_valid   = (w_count != 2'd0);
    assign out_last    = w_last;
    assign y_buf_en    = w_en;
    assign y_buf_wr_en = 1'b0;
    assign y_buf_addr  = r_addr;
    assign drain_busy  = r_busy;
    assign drain_done  = r_done;

endmodule

// File: tb/tb_y_buf_reader.sv
// Directed bench for y_buf_reader: a 32-bit-address instance for the main scenarios
// and a 4-bit-address instance for address wrap.
module tb_y_buf_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        drain_start;
    logic [31:0] base_addr;
    logic [15:0] num_words;
    logic        drain_busy, drain_done, y_buf_en, y_buf_wr_en;
    logic [31:0] y_buf_addr;
    logic [31:0] y_buf_rdata;
    logic        out_valid, out_ready, out_last;
    logic [31:0] out_data;

    logic        drain_start_w;
    logic [3:0]  base_w;
    logic [15:0] num_words_w;
    logic        busy_w, done_w, en_w, wr_en_w;
    logic [3:0]  addr_w;
    logic [31:0] rdata_w;
    logic        valid_w, last_w;
    logic [31:0] data_w;

    y_buf_reader u_dut (
        .clk(clk), .rst_n(rst_n), .drain_start(drain_start), .base_addr(base_addr),
        .num_words(num_words), .drain_busy(drain_busy), .drain_done(drain_done),
        .y_buf_en(y_buf_en), .y_buf_wr_en(y_buf_wr_en), .y_buf_addr(y_buf_addr),
        .y_buf_rdata(y_buf_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    y_buf_reader #(.OUT_BUF_ADDR_WIDTH(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .drain_start(drain_start_w), .base_addr(base_w),
        .num_words(num_words_w), .drain_busy(busy_w), .drain_done(done_w),
        .y_buf_en(en_w), .y_buf_wr_en(wr_en_w), .y_buf_addr(addr_w),
        .y_buf_rdata(rdata_w), .out_valid(valid_w), .out_ready(1'b1),
        .out_data(data_w), .out_last(last_w)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    function automatic logic [31:0] word_w(input logic [3:0] a);
        return 32'h5A5A_0000 + {28'd0, a};
    endfunction

    // Synchronous single-port buffer models with one-cycle read latency
    always @(posedge clk) if (y_buf_en) y_buf_rdata <= word_of(y_buf_addr);
    always @(posedge clk) if (en_w)     rdata_w     <= word_w(addr_w);

    int checks = 0;
    int errors = 0;

    logic        rec_en[64], rec_valid[64], rec_last[64], rec_done[64], rec_busy[64];
    logic [31:0] rec_addr[64], rec_data[64];
    logic        rec_en_w[64], rec_valid_w[64], rec_last_w[64], rec_done_w[64];
    logic [3:0]  rec_addr_w[64];
    logic [31:0] rec_data_w[64];

    logic [31:0] exp_q[$];
    int          issued, accepted, cur_n;
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_clear();
        exp_q.delete();
        issued     = 0;
        accepted   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic sample(input int c);
        logic pop;
        rec_en[c]    = y_buf_en;   rec_addr[c]  = y_buf_addr; rec_valid[c] = out_valid;
        rec_data[c]  = out_data;   rec_last[c]  = out_last;   rec_done[c]  = drain_done;
        rec_busy[c]  = drain_busy;
        rec_en_w[c]  = en_w;       rec_addr_w[c] = addr_w;    rec_valid_w[c] = valid_w;
        rec_data_w[c] = data_w;    rec_last_w[c] = last_w;    rec_done_w[c]  = done_w;
        chk("wr_en_tied_low", {y_buf_wr_en, wr_en_w}, 2'b00);
        pop = out_valid && out_ready;
        if (prev_stall) begin
            chk("stall_valid_held", out_valid, 1'b1);
            chk("stall_data_held", out_data, prev_data);
            chk("stall_last_held", out_last, prev_last);
        end
        if (y_buf_en) begin
            chk("occupancy_below_2", (issued - accepted - int'(pop)) < 2, 1'b1);
            exp_q.push_back(word_of(y_buf_addr));
            issued++;
        end
        if (pop) begin
            chk("pop_has_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) chk("stream_data", out_data, exp_q.pop_front());
            chk("stream_last", out_last, (accepted + 1) == cur_n);
            accepted++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
    endtask

    // Runs ncyc cycles from the cycle the start pulse is driven (cycle 0).
    task automatic drain(input logic [31:0] b, input logic [15:0] n, input int ncyc,
                         input int rmode, input bit use_w, input int s2,
                         input logic [31:0] b2, input logic [15:0] n2);
        cur_n      = int'(n);
        prev_stall = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            drain_start   = !use_w && (c == 0 || c == s2);
            base_addr     = (c == s2) ? b2 : b;
            num_words     = (c == s2) ? n2 : n;
            drain_start_w = use_w && (c == 0);
            base_w        = b[3:0];
            num_words_w   = n;
            out_ready     = (rmode == 0) ? 1'b1 : (c % 3 == 0);
            @(negedge clk);
            sample(c);
            @(posedge clk);
            #1;
        end
        drain_start   = 1'b0;
        drain_start_w = 1'b0;
        out_ready     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  drain_busy, 1'b0);
        chk({tag, "_done"},  drain_done, 1'b0);
        chk({tag, "_en"},    y_buf_en,   1'b0);
        chk({tag, "_addr"},  y_buf_addr, 32'd0);
        chk({tag, "_valid"}, out_valid,  1'b0);
        chk({tag, "_data"},  out_data,   32'd0);
        chk({tag, "_last"},  out_last,   1'b0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0; drain_start = 1'b0; base_addr = '0; num_words = '0; out_ready = 1'b1;
        drain_start_w = 1'b0; base_w = '0; num_words_w = '0;
        sb_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic drain: base 0x10, four words, no backpressure
        sb_clear();
        drain(32'h10, 16'd4, 10, 0, 1'b0, -1, 32'h0, 16'd0);
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("basic_en_c%0d", c), rec_en[c], (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk($sformatf("basic_addr_c%0d", c), rec_addr[c], 32'h10 + c - 1);
            chk($sformatf("basic_valid_c%0d", c), rec_valid[c], (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk($sformatf("basic_data_c%0d", c), rec_data[c], word_of(32'h10 + c - 3));
            chk($sformatf("basic_last_c%0d", c), rec_last[c], (c == 6));
            chk($sformatf("basic_done_c%0d", c), rec_done[c], (c == 7));
            chk($sformatf("basic_busy_c%0d", c), rec_busy[c], (c >= 1 && c <= 6));
        end
        chk("basic_accepted", accepted, 4);

        // Backpressure: eight words with out_ready = 1,0,0,1,0,0,...
        sb_clear();
        drain(32'h100, 16'd8, 30, 1, 1'b0, -1, 32'h0, 16'd0);
        cnt = 0;
        for (int c = 0; c < 30; c++) cnt += int'(rec_done[c]);
        chk("bp_issued", issued, 8);
        chk("bp_accepted", accepted, 8);
        chk("bp_done_pulses", cnt, 1);
        chk("bp_done_c25", rec_done[25], 1'b1);

        // Zero length: no reads, no stream, done at cycle 1
        sb_clear();
        drain(32'h50, 16'd0, 5, 0, 1'b0, -1, 32'h0, 16'd0);
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("zero_en_c%0d", c), rec_en[c], 1'b0);
            chk($sformatf("zero_valid_c%0d", c), rec_valid[c], 1'b0);
            chk($sformatf("zero_busy_c%0d", c), rec_busy[c], 1'b0);
            chk($sformatf("zero_done_c%0d", c), rec_done[c], (c == 1));
        end

        // Address wrap on the 4-bit-address instance: E, F, 0, 1
        sb_clear();
        drain(32'hE, 16'd4, 10, 0, 1'b1, -1, 32'h0, 16'd0);
        for (int c = 0; c < 10; c++) begin
            logic [3:0] ea;
            chk($sformatf("wrap_en_c%0d", c), rec_en_w[c], (c >= 1 && c <= 4));
            ea = 4'hE + 4'(c - 1);
            if (c >= 1 && c <= 4) chk($sformatf("wrap_addr_c%0d", c), rec_addr_w[c], ea);
            ea = 4'hE + 4'(c - 3);
            chk($sformatf("wrap_valid_c%0d", c), rec_valid_w[c], (c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) chk($sformatf("wrap_data_c%0d", c), rec_data_w[c], word_w(ea));
            chk($sformatf("wrap_last_c%0d", c), rec_last_w[c], (c == 6));
            chk($sformatf("wrap_done_c%0d", c), rec_done_w[c], (c == 7));
        end
        chk("wrap_main_idle", issued, 0);

        // Second start while busy must be ignored
        sb_clear();
        drain(32'h40, 16'd5, 12, 0, 1'b0, 2, 32'h80, 16'd2);
        for (int c = 1; c <= 5; c++) chk($sformatf("busy_addr_c%0d", c), rec_addr[c], 32'h40 + c - 1);
        chk("busy_issued", issued, 5);
        chk("busy_accepted", accepted, 5);
        chk("busy_done_c8", rec_done[8], 1'b1);
        chk("busy_en_c6", rec_en[6], 1'b0);

        // Reset after two words accepted, then a fresh three-word drain
        sb_clear();
        drain(32'h20, 16'd6, 5, 0, 1'b0, -1, 32'h0, 16'd0);
        chk("rst_pre_accepted", accepted, 2);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        sb_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;
        drain(32'h30, 16'd3, 9, 0, 1'b0, -1, 32'h0, 16'd0);
        for (int c = 0; c < 9; c++) begin
            chk($sformatf("post_en_c%0d", c), rec_en[c], (c >= 1 && c <= 3));
            if (c >= 1 && c <= 3) chk($sformatf("post_addr_c%0d", c), rec_addr[c], 32'h30 + c - 1);
            chk($sformatf("post_done_c%0d", c), rec_done[c], (c == 6));
        end
        chk("post_accepted", accepted, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
